// File: rtl/acorn128_rx_verify.sv
// Receive-side ACORN-128 authenticated decryption controller: drives the core in
// decrypt mode, checks the tag and releases plaintext only on a match.
// Optional core watchdog enabled by defining ACORN_RX_TIMEOUT_EN.
module acorn128_rx_verify #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] key_in,
  input  logic [127:0] iv_in,
  input  logic [127:0] associated_data_in,
  input  logic [127:0] ciphertext_in,
  input  logic [127:0] tag_in,
  input  logic [63:0]  data_length_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] plaintext_out,
  output logic [1:0]   status_out,
  output logic         core_rst,
  output logic         core_start,
  output logic         core_encrypt,
  output logic [127:0] core_key,
  output logic [127:0] core_iv,
  output logic [127:0] core_ad,
  output logic [127:0] core_text,
  output logic [63:0]  core_len,
  input  logic         core_ready,
  input  logic [127:0] core_text_out,
  input  logic [127:0] core_tag_out
);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, CHECK, OUT} state_t;

  localparam logic [1:0] ST_OK       = 2'b01;
  localparam logic [1:0] ST_MISMATCH = 2'b10;

  state_t       state;
  logic         run_first;
  logic [127:0] tag_q;
  logic [127:0] cap_text;
  logic [127:0] cap_tag;
  logic         tag_bad;

`ifdef ACORN_RX_TIMEOUT_EN
  localparam logic [1:0]  ST_TIMEOUT    = 2'b11;
  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);
  logic [31:0] run_cnt;
`endif

  // Full-width XOR-reduce so every tag bit participates, with no early exit.
  assign tag_bad      = |(cap_tag ^ tag_q);
  assign in_ready     = (state == IDLE) && !rst;
  assign core_rst     = rst || (state == CLEAR);
  assign core_encrypt = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      run_first     <= 1'b0;
      core_start    <= 1'b0;
      out_valid     <= 1'b0;
      plaintext_out <= '0;
      status_out    <= 2'b00;
      core_key      <= '0;
      core_iv       <= '0;
      core_ad       <= '0;
      core_text     <= '0;
      core_len      <= '0;
      tag_q         <= '0;
      cap_text      <= '0;
      cap_tag       <= '0;
`ifdef ACORN_RX_TIMEOUT_EN
      run_cnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            core_key  <= key_in;
            core_iv   <= iv_in;
            core_ad   <= associated_data_in;
            core_text <= ciphertext_in;
            core_len  <= data_length_in;
            tag_q     <= tag_in;
            state     <= CLEAR;
          end
        end
        CLEAR: begin
          core_start <= 1'b1;
          run_first  <= 1'b1;
`ifdef ACORN_RX_TIMEOUT_EN
          run_cnt    <= '0;
`endif
          state      <= RUN;
        end
        RUN: begin
          run_first <= 1'b0;
`ifdef ACORN_RX_TIMEOUT_EN
          run_cnt   <= run_cnt + 32'd1;
`endif
          // The first RUN cycle may still see ready left over from the previous packet.
          if (!run_first && core_ready) begin
            cap_text   <= core_text_out;
            cap_tag    <= core_tag_out;
            core_start <= 1'b0;
            state      <= CHECK;
          end
`ifdef ACORN_RX_TIMEOUT_EN
          else if (run_cnt == TIMEOUT_LIMIT) begin
            core_start    <= 1'b0;
            out_valid     <= 1'b1;
            plaintext_out <= '0;
            status_out    <= ST_TIMEOUT;
            state         <= OUT;
          end
`endif
        end
        CHECK: begin
          if (tag_bad) begin
            plaintext_out <= '0;
            status_out    <= ST_MISMATCH;
          end else begin
            plaintext_out <= cap_text;
            status_out    <= ST_OK;
          end
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            // Scrub every packet-derived register so no plaintext outlives the packet.
            out_valid     <= 1'b0;
            plaintext_out <= '0;
            cap_text      <= '0;
            cap_tag       <= '0;
            tag_q         <= '0;
            core_key      <= '0;
            core_iv       <= '0;
            core_ad       <= '0;
            core_text     <= '0;
            core_len      <= '0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_acorn128_rx_verify.sv
// Directed self-checking bench for acorn128_rx_verify with a simple behavioural
// core model (ready after 20 RUN cycles, text = ct ^ key, tag = key ^ iv).
module tb_acorn128_rx_verify;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready;
  logic [127:0] key_in, iv_in, associated_data_in, ciphertext_in, tag_in;
  logic [63:0]  data_length_in;
  logic         out_valid, out_ready;
  logic [127:0] plaintext_out;
  logic [1:0]   status_out;
  logic         core_rst, core_start, core_encrypt;
  logic [127:0] core_key, core_iv, core_ad, core_text;
  logic [63:0]  core_len;
  logic         core_ready;
  logic [127:0] core_text_out, core_tag_out;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int hs_cycle = 0;
  int ready_cycle = 0;
  int run_cnt = 0;
  bit never_ready = 1'b0;

  localparam logic [127:0] KEY1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] IV1  = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] CT1  = 128'hAABBCCDDEEFF00112233445566778899;
  localparam logic [127:0] TAG1 = 128'h01326754CDFEAB9889BAEFDC45762310;
  localparam logic [127:0] PT1  = 128'hAAAAEEEEAAAA6666AAAAEEEEAAAA6666;
  localparam logic [127:0] KEY2 = {16{8'hEE}};
  localparam logic [127:0] IV2  = {16{8'hFF}};
  localparam logic [127:0] CT2  = {16{8'h5A}};
  localparam logic [127:0] TAG2 = {16{8'h11}};
  localparam logic [127:0] PT2  = {16{8'hB4}};

  acorn128_rx_verify #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .key_in(key_in), .iv_in(iv_in), .associated_data_in(associated_data_in),
    .ciphertext_in(ciphertext_in), .tag_in(tag_in), .data_length_in(data_length_in),
    .out_valid(out_valid), .out_ready(out_ready), .plaintext_out(plaintext_out),
    .status_out(status_out), .core_rst(core_rst), .core_start(core_start),
    .core_encrypt(core_encrypt), .core_key(core_key), .core_iv(core_iv),
    .core_ad(core_ad), .core_text(core_text), .core_len(core_len),
    .core_ready(core_ready), .core_text_out(core_text_out), .core_tag_out(core_tag_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: counts cycles with start held and raises ready after 20 of them.
  initial begin
    core_ready = 1'b0;
    core_text_out = '0;
    core_tag_out = '0;
    forever begin
      @(negedge clk);
      if (core_rst) begin
        run_cnt = 0;
        core_ready = 1'b0;
      end else if (core_start) begin
        run_cnt++;
        if (run_cnt >= 20 && !never_ready && !core_ready) begin
          core_ready = 1'b1;
          ready_cycle = cyc + 1;
        end
      end
      core_text_out = core_text ^ core_key;
      core_tag_out = core_key ^ core_iv;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic presentPacket(input logic [127:0] k, input logic [127:0] iv,
                               input logic [127:0] ct, input logic [127:0] tg);
    key_in = k;
    iv_in = iv;
    ciphertext_in = ct;
    tag_in = tg;
    associated_data_in = k ^ ct;
    data_length_in = 64'd16;
    in_valid = 1'b1;
  endtask

  task automatic waitHandshake(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (in_ready) begin
        @(posedge clk);
        @(negedge clk);
        hs_cycle = cyc;
        in_valid = 1'b0;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) begin
      checkOutput({name, "_handshake_timeout"}, 128'd0, 128'd1);
      in_valid = 1'b0;
    end
  endtask

  task automatic applyStimulus(input string name, input logic [127:0] k, input logic [127:0] iv,
                               input logic [127:0] ct, input logic [127:0] tg);
    presentPacket(k, iv, ct, tg);
    waitHandshake(name);
  endtask

  task automatic waitResult(input string name, input logic [127:0] exp_pt,
                            input logic [1:0] exp_st, output int ov_cyc);
    bit found;
    found = 1'b0;
    ov_cyc = -1;
    for (int i = 0; i < 300 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        ov_cyc = cyc;
      end
    end
    if (!found) begin
      checkOutput({name, "_result_timeout"}, 128'd0, 128'd1);
    end else begin
      checkOutput({name, "_plaintext"}, plaintext_out, exp_pt);
      checkOutput({name, "_status"}, 128'(status_out), 128'(exp_st));
    end
  endtask

  // Called with out_ready high: one edge later the result must be gone and the block idle.
  task automatic finishResult(input string name, input logic [1:0] exp_st);
    @(negedge clk);
    checkOutput({name, "_post_valid"}, 128'(out_valid), 128'd0);
    checkOutput({name, "_post_plaintext"}, plaintext_out, 128'd0);
    checkOutput({name, "_post_status"}, 128'(status_out), 128'(exp_st));
    checkOutput({name, "_post_in_ready"}, 128'(in_ready), 128'd1);
  endtask

  initial begin
    int ov;
    int set_cyc;
    int bad;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    key_in = '0; iv_in = '0; associated_data_in = '0;
    ciphertext_in = '0; tag_in = '0; data_length_in = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", 128'(in_ready), 128'd0);
    checkOutput("rst_core_rst", 128'(core_rst), 128'd1);
    checkOutput("rst_core_start", 128'(core_start), 128'd0);
    checkOutput("rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("rst_plaintext", plaintext_out, 128'd0);
    checkOutput("rst_status", 128'(status_out), 128'd0);
    checkOutput("rst_core_key", core_key, 128'd0);
    checkOutput("rst_core_encrypt", 128'(core_encrypt), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", 128'(in_ready), 128'd1);
    checkOutput("post_rst_core_rst", 128'(core_rst), 128'd0);

    $display("[TB] matching tag");
    out_ready = 1'b1;
    applyStimulus("tc1", KEY1, IV1, CT1, TAG1);
    checkOutput("tc1_clear_core_rst", 128'(core_rst), 128'd1);
    checkOutput("tc1_clear_core_start", 128'(core_start), 128'd0);
    checkOutput("tc1_core_key", core_key, KEY1);
    @(negedge clk);
    checkOutput("tc1_run_core_start", 128'(core_start), 128'd1);
    checkOutput("tc1_run_core_rst", 128'(core_rst), 128'd0);
    waitResult("tc1", PT1, 2'b01, ov);
    checkOutput("tc1_ready_edge", 128'(ready_cycle), 128'(hs_cycle + 21));
    checkOutput("tc1_out_valid_edge", 128'(ov), 128'(ready_cycle + 1));
    finishResult("tc1", 2'b01);

    $display("[TB] tag bit 0 flipped");
    applyStimulus("tc2", KEY1, IV1, CT1, TAG1 ^ 128'd1);
    waitResult("tc2", 128'd0, 2'b10, ov);
    finishResult("tc2", 2'b10);

    $display("[TB] tag bit 127 flipped");
    applyStimulus("tc3", KEY1, IV1, CT1, TAG1 ^ {1'b1, 127'd0});
    waitResult("tc3", 128'd0, 2'b10, ov);
    finishResult("tc3", 2'b10);

    $display("[TB] held output then back-to-back packets");
    out_ready = 1'b0;
    applyStimulus("tc4", KEY1, IV1, CT1, TAG1);
    waitResult("tc4", PT1, 2'b01, ov);
    presentPacket(KEY2, IV2, CT2, TAG2);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || plaintext_out !== PT1 || status_out !== 2'b01 || in_ready) bad++;
    end
    checkOutput("tc4_hold_stable", 128'(bad), 128'd0);
    out_ready = 1'b1;
    set_cyc = cyc;
    waitHandshake("tc5");
    checkOutput("tc5_handshake_edge", 128'(hs_cycle), 128'(set_cyc + 2));
    waitResult("tc5", PT2, 2'b01, ov);
    finishResult("tc5", 2'b01);
    applyStimulus("tc6", KEY1, IV1, CT1, TAG1);
    waitResult("tc6", PT1, 2'b01, ov);
    finishResult("tc6", 2'b01);

    $display("[TB] reset during RUN");
    applyStimulus("tc7", KEY2, IV2, CT2, TAG2);
    repeat (5) @(negedge clk);
    checkOutput("tc7_in_run", 128'(core_start), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("tc7_rst_out_valid", 128'(out_valid), 128'd0);
    checkOutput("tc7_rst_core_start", 128'(core_start), 128'd0);
    checkOutput("tc7_rst_core_rst", 128'(core_rst), 128'd1);
    checkOutput("tc7_rst_status", 128'(status_out), 128'd0);
    checkOutput("tc7_rst_core_text", core_text, 128'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("tc7_idle_in_ready", 128'(in_ready), 128'd1);
    applyStimulus("tc8", KEY2, IV2, CT2, TAG2);
    waitResult("tc8", PT2, 2'b01, ov);
    finishResult("tc8", 2'b01);

    $display("[TB] core never ready");
    never_ready = 1'b1;
    applyStimulus("tc9", KEY1, IV1, CT1, TAG1);
`ifdef ACORN_RX_TIMEOUT_EN
    waitResult("tc9", 128'd0, 2'b11, ov);
    checkOutput("tc9_timeout_edge", 128'(ov), 128'(hs_cycle + 18));
    checkOutput("tc9_core_start", 128'(core_start), 128'd0);
    finishResult("tc9", 2'b11);
`else
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (out_valid || !core_start || in_ready) bad++;
    end
    checkOutput("tc9_stays_in_run", 128'(bad), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`endif
    never_ready = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
